// File: rtl/cxapbasyncbridge_cdc_filt_sync.sv
// rtl/cxapbasyncbridge_cdc_filt_sync.sv - multi-bit CDC capture synchroniser with word-level stability filter
//
// Destination-side capture point for asynchronous status/control vectors
// entering the clk domain. A STAGES-deep flop chain synchronises d_async; an
// optional filter then requires the whole synchronised word to hold one value
// for STABLE_CNT further enabled samples before q is updated, so a partially
// settled multi-bit value never reaches q.
//
// Parameters:
//   WIDTH      - captured vector width (>= 1)
//   STAGES     - synchroniser depth (2..4)
//   STABLE_CNT - extra unchanged enabled samples before q updates (0..15),
//                0 selects bypass (q follows the last synchroniser stage)
//   RESET_VAL  - reset value of synchroniser stages, history register and q
//
// Ports:
//   clk      in   destination clock
//   resetn   in   asynchronous active-low reset
//   d_async  in   asynchronous source vector (WIDTH)
//   sync_en  in   sample enable; when low all state holds
//   q        out  filtered, synchronised vector (WIDTH)
//   q_chg    out  one-cycle pulse in the cycle after q changes
//   pending  out  synchronised word differs from q (always 0 in bypass)

module cxapbasyncbridge_cdc_filt_sync #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               STABLE_CNT = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_async,
    input  logic             sync_en,
    output logic [WIDTH-1:0] q,
    output logic             q_chg,
    output logic             pending
);

    // Synchroniser chain. sync_r[0] is the only flop that samples d_async and
    // nothing combinational sits in front of it.
    logic [STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]             s;
    logic [WIDTH-1:0]             q_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else if (sync_en) begin
            sync_r <= {sync_r[STAGES-2:0], d_async};
        end
    end

    assign s = sync_r[STAGES-1];

    generate
        if (STABLE_CNT == 0) begin : g_bypass
            // q is the last stage itself; its next value is the stage feeding it.
            assign q       = s;
            assign q_next  = sync_en ? sync_r[STAGES-2] : s;
            assign pending = 1'b0;
        end else begin : g_filter
            localparam int             CW      = $clog2(STABLE_CNT + 1);
            localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT - 1);

            logic [WIDTH-1:0] s_d;
            logic [WIDTH-1:0] q_r;
            logic [CW-1:0]    cnt;
            logic             qualify;

            // Word-wide compare: a toggle on any bit restarts qualification.
            assign qualify = (s == s_d) && (cnt == CNT_MAX);

            always_comb begin
                q_next = q_r;
                if (sync_en && qualify) begin
                    q_next = s;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    s_d <= RESET_VAL;
                    cnt <= '0;
                    q_r <= RESET_VAL;
                end else if (sync_en) begin
                    s_d <= s;
                    if (s != s_d) begin
                        cnt <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    q_r <= q_next;
                end
            end

            assign q       = q_r;
            assign pending = (s != q_r);
        end
    endgenerate

    // Updated on every edge (not gated by sync_en) so the pulse is exactly one
    // cycle wide even if sync_en drops right after the update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_chg <= 1'b0;
        end else begin
            q_chg <= (q_next != q);
        end
    end

endmodule

// File: tb/tb_cxapbasyncbridge_cdc_filt_sync.sv
// tb/tb_cxapbasyncbridge_cdc_filt_sync.sv - directed self-checking bench for cxapbasyncbridge_cdc_filt_sync

module tb_cxapbasyncbridge_cdc_filt_sync;

    logic       clk;
    logic       resetn;
    logic [3:0] d_async;
    logic       sync_en;

    logic [3:0] q_rst, q_flt, q_gl, q_en, q_byp;
    logic       chg_rst, chg_flt, chg_gl, chg_en, chg_byp;
    logic       pend_rst, pend_flt, pend_gl, pend_en, pend_byp;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RESET_VAL = A, STAGES 2, STABLE_CNT 2
    cxapbasyncbridge_cdc_filt_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(2), .RESET_VAL(4'hA)) dut_rst (
        .clk(clk), .resetn(resetn), .d_async(d_async), .sync_en(sync_en),
        .q(q_rst), .q_chg(chg_rst), .pending(pend_rst));

    // STAGES 2, STABLE_CNT 2
    cxapbasyncbridge_cdc_filt_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(2), .RESET_VAL(4'h0)) dut_flt (
        .clk(clk), .resetn(resetn), .d_async(d_async), .sync_en(sync_en),
        .q(q_flt), .q_chg(chg_flt), .pending(pend_flt));

    // STAGES 2, STABLE_CNT 3
    cxapbasyncbridge_cdc_filt_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(3), .RESET_VAL(4'h0)) dut_gl (
        .clk(clk), .resetn(resetn), .d_async(d_async), .sync_en(sync_en),
        .q(q_gl), .q_chg(chg_gl), .pending(pend_gl));

    // STAGES 3, STABLE_CNT 1
    cxapbasyncbridge_cdc_filt_sync #(.WIDTH(4), .STAGES(3), .STABLE_CNT(1), .RESET_VAL(4'h0)) dut_en (
        .clk(clk), .resetn(resetn), .d_async(d_async), .sync_en(sync_en),
        .q(q_en), .q_chg(chg_en), .pending(pend_en));

    // bypass: STAGES 2, STABLE_CNT 0
    cxapbasyncbridge_cdc_filt_sync #(.WIDTH(4), .STAGES(2), .STABLE_CNT(0), .RESET_VAL(4'h0)) dut_byp (
        .clk(clk), .resetn(resetn), .d_async(d_async), .sync_en(sync_en),
        .q(q_byp), .q_chg(chg_byp), .pending(pend_byp));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        d_async = 4'h0;
        sync_en = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        d_async = 4'hA;
        sync_en = 1'b1;
        repeat (3) tick();
        checks++;
        if (q_rst !== 4'hA) begin
            errors++; $display("FAIL reset_q_in_reset: got %h want a", q_rst);
        end
        checks++;
        if (q_flt !== 4'h0) begin
            errors++; $display("FAIL reset_q_flt_in_reset: got %h want 0", q_flt);
        end
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (q_rst !== 4'hA || chg_rst !== 1'b0 || pend_rst !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: q=%h chg=%b pend=%b want q=a chg=0 pend=0",
                         k, q_rst, chg_rst, pend_rst);
            end
        end
    endtask

    task automatic test_filter_latency();
        logic [3:0] exp_q;
        logic       exp_chg, exp_pend;
        settle();
        d_async = 4'h5;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_q    = (k >= 5) ? 4'h5 : 4'h0;
            exp_chg  = (k == 5);
            exp_pend = (k >= 2 && k <= 4);
            checks++;
            if (q_flt !== exp_q || chg_flt !== exp_chg || pend_flt !== exp_pend) begin
                errors++;
                $display("FAIL filter_latency edge %0d: q=%h chg=%b pend=%b want q=%h chg=%b pend=%b",
                         k, q_flt, chg_flt, pend_flt, exp_q, exp_chg, exp_pend);
            end
        end
    endtask

    task automatic test_glitch();
        settle();
        d_async = 4'h3;
        tick();
        tick();
        checks++;
        if (pend_gl !== 1'b1) begin
            errors++; $display("FAIL glitch_pending_rise: got %b want 1", pend_gl);
        end
        d_async = 4'h0;
        tick();
        tick();
        checks++;
        if (pend_gl !== 1'b0) begin
            errors++; $display("FAIL glitch_pending_fall: got %b want 0", pend_gl);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (q_gl !== 4'h0 || chg_gl !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject cycle %0d: q=%h chg=%b want q=0 chg=0", k, q_gl, chg_gl);
            end
        end
    endtask

    task automatic test_word_coherence();
        logic [3:0] prev_q;
        int         changes;
        int         pulses;
        settle();
        // bit 3 steps to 1, bit 0 toggles every two cycles; ends holding 9
        for (int i = 0; i < 10; i++) begin
            d_async = {1'b1, 2'b00, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0};
            tick();
            checks++;
            if (q_flt !== 4'h0) begin
                errors++; $display("FAIL coherence_toggle cycle %0d: q=%h want 0", i, q_flt);
            end
        end
        d_async = 4'h9;
        prev_q  = q_flt;
        changes = 0;
        pulses  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (q_flt !== prev_q) changes++;
            if (chg_flt === 1'b1) pulses++;
            prev_q = q_flt;
        end
        checks++;
        if (q_flt !== 4'h9) begin
            errors++; $display("FAIL coherence_final_q: got %h want 9", q_flt);
        end
        checks++;
        if (changes != 1) begin
            errors++; $display("FAIL coherence_single_update: got %0d updates want 1", changes);
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL coherence_pulse_count: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_enable_gating();
        logic [3:0] exp_q;
        logic       exp_chg;
        settle();
        d_async = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            sync_en = (c % 2 == 1);
            tick();
            exp_q   = (c >= 9) ? 4'hF : 4'h0;
            exp_chg = (c == 9);
            checks++;
            if (q_en !== exp_q || chg_en !== exp_chg) begin
                errors++;
                $display("FAIL enable_gating clk %0d: q=%h chg=%b want q=%h chg=%b",
                         c, q_en, chg_en, exp_q, exp_chg);
            end
        end
        sync_en = 1'b1;
    endtask

    task automatic test_bypass();
        logic [3:0] exp_q;
        logic       exp_chg;
        settle();
        d_async = 4'h6;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_q   = (k >= 2) ? 4'h6 : 4'h0;
            exp_chg = (k == 2);
            checks++;
            if (q_byp !== exp_q || chg_byp !== exp_chg || pend_byp !== 1'b0) begin
                errors++;
                $display("FAIL bypass edge %0d: q=%h chg=%b pend=%b want q=%h chg=%b pend=0",
                         k, q_byp, chg_byp, pend_byp, exp_q, exp_chg);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_q;
        logic       exp_chg;
        settle();
        checks++;
        if (q_rst !== 4'h0) begin
            errors++; $display("FAIL midreset_pre_q: got %h want 0", q_rst);
        end
        d_async = 4'h5;
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (q_rst !== 4'hA || chg_rst !== 1'b0) begin
            errors++; $display("FAIL midreset_async: q=%h chg=%b want q=a chg=0", q_rst, chg_rst);
        end
        repeat (2) tick();
        resetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_q   = (k >= 5) ? 4'h5 : 4'hA;
            exp_chg = (k == 5);
            checks++;
            if (q_rst !== exp_q || chg_rst !== exp_chg) begin
                errors++;
                $display("FAIL midreset_requalify edge %0d: q=%h chg=%b want q=%h chg=%b",
                         k, q_rst, chg_rst, exp_q, exp_chg);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        d_async = 4'hA;
        sync_en = 1'b1;
        test_reset();
        test_filter_latency();
        test_glitch();
        test_word_coherence();
        test_enable_gating();
        test_bypass();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
